alu_16_b: RTL and testbench
===========================

ALU_16_B -- requirements
Module: alu_16_b

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data width of A, B and ALU_OUT; all requirements below are for 16.
REQ-002 SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port RST  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port A  input  16  operand A, unsigned.
REQ-005 SHALL have port B  input  16  operand B, unsigned; ignored by shifts.
REQ-006 SHALL have port ALU_FUN  input  4  operation select.
REQ-007 SHALL have port ALU_OUT  output  16  registered result.
REQ-008 SHALL have port Carry_Flag  output  1  registered carry/borrow.
REQ-009 SHALL have port Arith_Flag  output  1  registered; 1 when the captured op is arithmetic.
REQ-010 SHALL have port Logic_Flag  output  1  registered; 1 when the captured op is logic.
REQ-011 SHALL have port CMP_Flag  output  1  registered; 1 when the captured op is a compare.
REQ-012 SHALL have port Shift_Flag  output  1  registered; 1 when the captured op is a shift.

Function
REQ-013 SHALL capture A, B and ALU_FUN at each rising CLK and present the result and flags on the same edge: 1-cycle latency, no handshake, a new op every cycle.
REQ-014 SHALL implement ALU_FUN 0000 ADD: ALU_OUT = (A+B)[15:0]; Carry_Flag = bit 16 of the 17-bit sum.
REQ-015 SHALL implement 0001 SUB: ALU_OUT = (A-B) mod 2^16; Carry_Flag = 1 when A<B (borrow).
REQ-016 SHALL implement 0010 MUL: ALU_OUT = low 16 bits of A*B; Carry_Flag = 1 when the upper 16 bits of the product are non-zero.
REQ-017 SHALL implement 0011 DIV: ALU_OUT = floor(A/B); B=0 gives ALU_OUT = 0 and Carry_Flag = 0.
REQ-018 SHALL implement logic ops: 0100 AND, 0101 OR, 0110 NAND, 0111 NOR, 1000 XOR, 1001 XNOR, all bitwise.
REQ-019 SHALL implement 1010 CMPEQ: ALU_OUT = 1 if A==B, else 0.
REQ-020 SHALL implement 1011 CMPG: ALU_OUT = 2 if A>B, else 0.
REQ-021 SHALL implement 1100 CMPL: ALU_OUT = 3 if A<B, else 0.
REQ-022 SHALL implement 1101 SHR: ALU_OUT = A>>1, zero-fill at MSB; 1110 SHL: ALU_OUT = A<<1, zero-fill at LSB, MSB discarded.
REQ-023 SHALL treat 1111 as NOP: ALU_OUT = 0 and all flags = 0.
REQ-024 SHALL set Arith_Flag for 0000-0011, Logic_Flag for 0100-1001, CMP_Flag for 1010-1100 and Shift_Flag for 1101-1110; the flags are mutually exclusive.
REQ-025 SHALL hold Carry_Flag = 0 for every op other than ADD, SUB and MUL.
REQ-026 SHALL treat all arithmetic and compares as unsigned.

Reset
REQ-027 SHALL, while RST=0, force ALU_OUT=0 and all five flags=0 immediately, independent of CLK.
REQ-028 SHALL resume normal operation at the first rising CLK after RST deasserts; reset mid-operation discards the in-flight result.

Structure
REQ-029 SHALL place the opcode constants (ADD..SHL, NOP) and the compare result codes 1/2/3 in shared package alu_16_b_pkg.
REQ-030 SHALL be built as one flat module: combinational next-value logic plus one output register bank; no sub-module.

Verification
REQ-031 SHALL cover ADD: A=6, B=7, FUN=0000 -> ALU_OUT=13, Arith_Flag=1, Carry_Flag=0 one cycle later; A=FFFF, B=1 -> ALU_OUT=0, Carry_Flag=1.
REQ-032 SHALL cover SUB, MUL and DIV: 15-4 -> 11; 4*3 -> 12; 9/3 -> 3; 14/0 -> 0 with Arith_Flag=1.
REQ-033 SHALL cover logic ops with A=AAAA, B=5555: AND -> 0000, OR -> FFFF, NAND -> FFFF, NOR -> 0000, XOR -> FFFF, XNOR -> 0000, each with Logic_Flag=1.
REQ-034 SHALL cover compares: AAAA==AAAA -> 1; F>A -> 2; A<F -> 3; CMPG with A=A, B=F -> 0; each with CMP_Flag=1.
REQ-035 SHALL cover shifts: SHR A=14 -> 7; SHL A=6 -> 12; SHL A=8000 -> 0; each with Shift_Flag=1.
REQ-036 SHALL cover reset: assert RST=0 between clock edges -> all outputs 0 immediately; release RST -> the next edge yields the correct result.

Source files
------------

// File: rtl/alu_16_b_pkg.sv
// alu_16_b_pkg: opcode constants, compare result codes and op classification for alu_16_b
package alu_16_b_pkg;

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_MUL   = 4'h2;
    localparam logic [3:0] OP_DIV   = 4'h3;
    localparam logic [3:0] OP_AND   = 4'h4;
    localparam logic [3:0] OP_OR    = 4'h5;
    localparam logic [3:0] OP_NAND  = 4'h6;
    localparam logic [3:0] OP_NOR   = 4'h7;
    localparam logic [3:0] OP_XOR   = 4'h8;
    localparam logic [3:0] OP_XNOR  = 4'h9;
    localparam logic [3:0] OP_CMPEQ = 4'hA;
    localparam logic [3:0] OP_CMPG  = 4'hB;
    localparam logic [3:0] OP_CMPL  = 4'hC;
    localparam logic [3:0] OP_SHR   = 4'hD;
    localparam logic [3:0] OP_SHL   = 4'hE;
    localparam logic [3:0] OP_NOP   = 4'hF;

    localparam int unsigned CMP_EQ_CODE = 1;
    localparam int unsigned CMP_GT_CODE = 2;
    localparam int unsigned CMP_LT_CODE = 3;

    typedef enum logic [2:0] {CLS_ARITH, CLS_LOGIC, CLS_CMP, CLS_SHIFT, CLS_NONE} op_class_e;

    // Opcodes are grouped in contiguous ranges, so class falls out of ordered compares
    function automatic op_class_e op_class(input logic [3:0] fun);
        return fun <= OP_DIV  ? CLS_ARITH :
               fun <= OP_XNOR ? CLS_LOGIC :
               fun <= OP_CMPL ? CLS_CMP   :
               fun <= OP_SHL  ? CLS_SHIFT : CLS_NONE;
    endfunction

endpackage

// File: rtl/alu_16_b.sv
// alu_16_b: single-cycle unsigned ALU with a registered result and operation-class flags
module alu_16_b
    import alu_16_b_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALU_FUN,
    output logic [WIDTH-1:0] ALU_OUT,
    output logic             Carry_Flag,
    output logic             Arith_Flag,
    output logic             Logic_Flag,
    output logic             CMP_Flag,
    output logic             Shift_Flag
);

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] prod;
    op_class_e          cls;
    logic [WIDTH-1:0]   alu_out_d, alu_out_q;
    logic               carry_d, carry_q;
    logic               arith_d, arith_q;
    logic               logic_d, logic_q;
    logic               cmp_d, cmp_q;
    logic               shift_d, shift_q;

    always_comb begin
        sum       = {1'b0, A} + {1'b0, B};
        diff      = {1'b0, A} - {1'b0, B};
        prod      = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
        cls       = op_class(ALU_FUN);
        alu_out_d = '0;
        carry_d   = 1'b0;
        case (ALU_FUN)
            OP_ADD: begin
                alu_out_d = sum[WIDTH-1:0];
                carry_d   = sum[WIDTH];
            end
            OP_SUB: begin
                alu_out_d = diff[WIDTH-1:0];
                carry_d   = diff[WIDTH];
            end
            OP_MUL: begin
                alu_out_d = prod[WIDTH-1:0];
                carry_d   = |prod[2*WIDTH-1:WIDTH];
            end
            // Divide by zero yields zero rather than propagating an undefined quotient
            OP_DIV:   alu_out_d = (B == '0) ? '0 : A / B;
            OP_AND:   alu_out_d = A & B;
            OP_OR:    alu_out_d = A | B;
            OP_NAND:  alu_out_d = ~(A & B);
            OP_NOR:   alu_out_d = ~(A | B);
            OP_XOR:   alu_out_d = A ^ B;
            OP_XNOR:  alu_out_d = ~(A ^ B);
            OP_CMPEQ: alu_out_d = (A == B) ? WIDTH'(CMP_EQ_CODE) : '0;
            OP_CMPG:  alu_out_d = (A > B) ? WIDTH'(CMP_GT_CODE) : '0;
            OP_CMPL:  alu_out_d = (A < B) ? WIDTH'(CMP_LT_CODE) : '0;
            OP_SHR:   alu_out_d = A >> 1;
            OP_SHL:   alu_out_d = A << 1;
            default:  alu_out_d = '0;
        endcase
        arith_d = cls == CLS_ARITH;
        logic_d = cls == CLS_LOGIC;
        cmp_d   = cls == CLS_CMP;
        shift_d = cls == CLS_SHIFT;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            alu_out_q <= '0;
            carry_q   <= 1'b0;
            arith_q   <= 1'b0;
            logic_q   <= 1'b0;
            cmp_q     <= 1'b0;
            shift_q   <= 1'b0;
        end else begin
            alu_out_q <= alu_out_d;
            carry_q   <= carry_d;
            arith_q   <= arith_d;
            logic_q   <= logic_d;
            cmp_q     <= cmp_d;
            shift_q   <= shift_d;
        end
    end

    assign ALU_OUT    = alu_out_q;
    assign Carry_Flag = carry_q;
    assign Arith_Flag = arith_q;
    assign Logic_Flag = logic_q;
    assign CMP_Flag   = cmp_q;
    assign Shift_Flag = shift_q;

endmodule

// File: tb/tb_alu_16_b.sv
// tb_alu_16_b: directed scoreboard bench for alu_16_b
module tb_alu_16_b;
    import alu_16_b_pkg::*;

    typedef struct packed {
        logic [15:0] out;
        logic        carry;
        logic [3:0]  flags;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic [3:0]  ALU_FUN = OP_NOP;
    logic [15:0] ALU_OUT;
    logic        Carry_Flag, Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag;

    int   n_assert = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    alu_16_b dut (
        .CLK(CLK), .RST(RST), .A(A), .B(B), .ALU_FUN(ALU_FUN),
        .ALU_OUT(ALU_OUT), .Carry_Flag(Carry_Flag), .Arith_Flag(Arith_Flag),
        .Logic_Flag(Logic_Flag), .CMP_Flag(CMP_Flag), .Shift_Flag(Shift_Flag)
    );

    always #5 CLK = ~CLK;

    // {arith, logic, cmp, shift}
    function automatic logic [3:0] flags_of(input logic [3:0] f);
        logic [3:0] tbl [16] = '{4'b1000, 4'b1000, 4'b1000, 4'b1000,
                                 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100,
                                 4'b0010, 4'b0010, 4'b0010,
                                 4'b0001, 4'b0001, 4'b0000};
        return tbl[f];
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        n_assert++;
        assert (sb.size() != 0) else begin
            n_fail++;
            $error("FAIL %s: observed empty scoreboard expected one entry", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check_val({tag, ".out"}, 32'(ALU_OUT), 32'(e.out));
            check_val({tag, ".carry"}, 32'(Carry_Flag), 32'(e.carry));
            check_val({tag, ".flags"}, 32'({Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag}), 32'(e.flags));
        end
    endtask

    task automatic check_zero(input string tag);
        check_val(tag, 32'({ALU_OUT, Carry_Flag, Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag}), 32'h0);
    endtask

    task automatic step(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] f, input logic [15:0] eo, input logic ec);
        @(negedge CLK);
        A = a;
        B = b;
        ALU_FUN = f;
        sb.push_back('{eo, ec, flags_of(f)});
        @(posedge CLK);
        #1;
        check_out(tag);
    endtask

    initial begin
        #1;
        check_zero("reset_initial");
        @(negedge CLK);
        A = 16'h1234;
        B = 16'h0001;
        ALU_FUN = OP_ADD;
        @(posedge CLK);
        #1;
        check_zero("reset_held_edge");
        #2 RST = 1'b1;

        step("add_6_7",      16'h0006, 16'h0007, OP_ADD,   16'h000D, 1'b0);
        step("add_ffff_1",   16'hFFFF, 16'h0001, OP_ADD,   16'h0000, 1'b1);
        step("sub_15_4",     16'h000F, 16'h0004, OP_SUB,   16'h000B, 1'b0);
        step("sub_borrow",   16'h0004, 16'h0005, OP_SUB,   16'hFFFF, 1'b1);
        step("mul_4_3",      16'h0004, 16'h0003, OP_MUL,   16'h000C, 1'b0);
        step("mul_ovf",      16'h0100, 16'h0100, OP_MUL,   16'h0000, 1'b1);
        step("div_9_3",      16'h0009, 16'h0003, OP_DIV,   16'h0003, 1'b0);
        step("div_14_0",     16'h000E, 16'h0000, OP_DIV,   16'h0000, 1'b0);
        step("and",          16'hAAAA, 16'h5555, OP_AND,   16'h0000, 1'b0);
        step("or",           16'hAAAA, 16'h5555, OP_OR,    16'hFFFF, 1'b0);
        step("nand",         16'hAAAA, 16'h5555, OP_NAND,  16'hFFFF, 1'b0);
        step("nor",          16'hAAAA, 16'h5555, OP_NOR,   16'h0000, 1'b0);
        step("xor",          16'hAAAA, 16'h5555, OP_XOR,   16'hFFFF, 1'b0);
        step("xnor",         16'hAAAA, 16'h5555, OP_XNOR,  16'h0000, 1'b0);
        step("and_mixed",    16'hF0F0, 16'h3C3C, OP_AND,   16'h3030, 1'b0);
        step("cmpeq_t",      16'hAAAA, 16'hAAAA, OP_CMPEQ, 16'h0001, 1'b0);
        step("cmpeq_f",      16'hAAAA, 16'hAAAB, OP_CMPEQ, 16'h0000, 1'b0);
        step("cmpg_t",       16'h000F, 16'h000A, OP_CMPG,  16'h0002, 1'b0);
        step("cmpl_t",       16'h000A, 16'h000F, OP_CMPL,  16'h0003, 1'b0);
        step("cmpg_f",       16'h000A, 16'h000F, OP_CMPG,  16'h0000, 1'b0);
        step("cmpg_unsigned",16'h8000, 16'h0001, OP_CMPG,  16'h0002, 1'b0);
        step("shr_14",       16'h000E, 16'hFFFF, OP_SHR,   16'h0007, 1'b0);
        step("shr_msb",      16'h8001, 16'h0000, OP_SHR,   16'h4000, 1'b0);
        step("shl_6",        16'h0006, 16'hFFFF, OP_SHL,   16'h000C, 1'b0);
        step("shl_8000",     16'h8000, 16'h0000, OP_SHL,   16'h0000, 1'b0);
        step("nop",          16'hFFFF, 16'hFFFF, OP_NOP,   16'h0000, 1'b0);
        step("add_after_nop",16'h1234, 16'h1111, OP_ADD,   16'h2345, 1'b0);

        // asynchronous reset asserted between edges, released before the next edge
        RST = 1'b0;
        #1;
        check_zero("reset_async");
        #1 RST = 1'b1;
        step("post_reset_sub", 16'h0064, 16'h0032, OP_SUB, 16'h0032, 1'b0);

        // reset mid-operation: drive an op, then pulse reset before its edge
        @(negedge CLK);
        A = 16'h00FF;
        B = 16'h0001;
        ALU_FUN = OP_ADD;
        #1 RST = 1'b0;
        #1;
        check_zero("reset_midop");
        @(posedge CLK);
        #1;
        check_zero("reset_discard");
        #1 RST = 1'b1;
        step("post_reset_mul", 16'h0010, 16'h0010, OP_MUL, 16'h0100, 1'b0);

        check_val("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
